// File: rtl/byte_unstriping.sv
// ---------------------------------------------------------------------------
// byte_unstriping
//   Receive-side lane merger. Two DATA_W-bit lanes each feed a small deskew
//   FIFO. The output stream reads the FIFOs in strict alternation
//   (lane 0, lane 1, lane 0, ...), regardless of which lane arrived first.
//   This restores the word order that the transmit-side striper distributed.
//   An empty FIFO is never bypassed, so a word pushed at one edge can be
//   popped at the following edge at the earliest.
//
// Parameters
//   DATA_W    lane and output word width
//   DEPTH     entries per lane FIFO (power of 2, >= 2)
//
// Ports
//   clk        in   single clock, all state on posedge
//   reset      in   asynchronous active-high reset
//   lane_0     in   lane 0 word
//   valid_0    in   lane_0 valid this cycle
//   lane_1     in   lane 1 word
//   valid_1    in   lane_1 valid this cycle
//   data_out   out  merged word (registered, holds when idle)
//   valid_out  out  data_out valid (registered)
//   err_ovf    out  sticky overflow flag (only when UNSTRIPE_ERR_EN is defined)
//
// Build option
//   UNSTRIPE_ERR_EN  adds the err_ovf port. It is set by any write dropped
//                    on a full FIFO and is cleared only by reset. With the
//                    macro undefined, dropped writes are silent.
// ---------------------------------------------------------------------------
module byte_unstriping #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out
`ifdef UNSTRIPE_ERR_EN
    ,
    output logic              err_ovf
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LANES = 2;

    typedef enum logic {
        SEL_LANE0 = 1'b0,
        SEL_LANE1 = 1'b1
    } sel_e;

    // FIFO storage and state
    logic [DATA_W-1:0] mem_q    [LANES][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [LANES];
    logic [PTR_W-1:0]  wr_ptr_d [LANES];
    logic [PTR_W-1:0]  rd_ptr_q [LANES];
    logic [PTR_W-1:0]  rd_ptr_d [LANES];
    logic [CNT_W-1:0]  cnt_q    [LANES];
    logic [CNT_W-1:0]  cnt_d    [LANES];

    // Output side state
    sel_e              sel_q;
    sel_e              sel_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;

    // Per-lane combinational view
    logic [DATA_W-1:0] lane_data  [LANES];
    logic              lane_valid [LANES];
    logic              empty      [LANES];
    logic              full       [LANES];
    logic              pop        [LANES];
    logic              push       [LANES];
    logic              sel_idx;

    always_comb begin
        lane_data[0]  = lane_0;
        lane_data[1]  = lane_1;
        lane_valid[0] = valid_0;
        lane_valid[1] = valid_1;
        sel_idx       = (sel_q == SEL_LANE1);

        for (int unsigned l = 0; l < LANES; l++) begin
            empty[l] = (cnt_q[l] == '0);
            full[l]  = (cnt_q[l] == CNT_W'(DEPTH));
        end

        // Only the lane named by sel may pop.
        pop[0] = !sel_idx && !empty[0];
        pop[1] =  sel_idx && !empty[1];

        for (int unsigned l = 0; l < LANES; l++) begin
            // A same-cycle pop frees a slot, so a full FIFO still accepts.
            push[l]     = lane_valid[l] && (!full[l] || pop[l]);
            wr_ptr_d[l] = wr_ptr_q[l] + PTR_W'(push[l]);
            rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(pop[l]);
            cnt_d[l]    = cnt_q[l] + CNT_W'(push[l]) - CNT_W'(pop[l]);
        end

        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (pop[sel_idx]) begin
            data_d  = mem_q[sel_idx][rd_ptr_q[sel_idx]];
            valid_d = 1'b1;
            sel_d   = (sel_q == SEL_LANE0) ? SEL_LANE1 : SEL_LANE0;
        end
    end

    // Storage needs no reset: the cleared pointers and counts hide stale entries.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (push[l]) begin
                mem_q[l][wr_ptr_q[l]] <= lane_data[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
            end
            sel_q   <= SEL_LANE0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                wr_ptr_q[l] <= wr_ptr_d[l];
                rd_ptr_q[l] <= rd_ptr_d[l];
                cnt_q[l]    <= cnt_d[l];
            end
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

`ifdef UNSTRIPE_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_valid[l] && !push[l]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_ovf = err_q;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// ---------------------------------------------------------------------------
// tb_byte_unstriping
//   Directed testbench for byte_unstriping (DATA_W=32, DEPTH=4).
//   The bench drives inputs one cycle at a time and samples outputs 1 time
//   unit after each rising edge. Expected values are hand-derived constants.
//   err_ovf is checked only when UNSTRIPE_ERR_EN is defined.
// ---------------------------------------------------------------------------
module tb_byte_unstriping;

    logic        clk;
    logic        reset;
    logic [31:0] lane_0;
    logic        valid_0;
    logic [31:0] lane_1;
    logic        valid_1;
    logic [31:0] data_out;
    logic        valid_out;
`ifdef UNSTRIPE_ERR_EN
    logic        err_ovf;
`endif

    int checks;
    int errors;

    byte_unstriping #(
        .DATA_W(32),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out)
`ifdef UNSTRIPE_ERR_EN
        ,
        .err_ovf  (err_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of lane inputs. Return 1 time unit after the edge.
    task automatic cycle(input logic v0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] d1);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [31:0] ed);
        check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, ev});
        if (ev) begin
            check({tag, ".data"}, data_out, ed);
        end
    endtask

    task automatic check_err(input string tag, input logic ee);
`ifdef UNSTRIPE_ERR_EN
        check({tag, ".err"}, {31'b0, err_ovf}, {31'b0, ee});
`else
        if (ee) begin
        end
        if (tag.len() == 0) begin
        end
`endif
    endtask

    // Reset asserted and released between clock edges
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        lane_0  = '0;
        lane_1  = '0;

        // Reset state
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst.data", data_out, 32'h0);
        check("rst.valid", {31'b0, valid_out}, 32'h0);
        check_err("rst", 1'b0);
        reset = 1'b0;

        // 1: aligned burst
        cycle(1'b1, 32'hFFFFFFFF, 1'b1, 32'hEEEEEEEE); expect_out("t1.c0", 1'b0, 32'h0);
        cycle(1'b1, 32'hDDDDDDDD, 1'b1, 32'hCCCCCCCC); expect_out("t1.c1", 1'b1, 32'hFFFFFFFF);
        idle(); expect_out("t1.c2", 1'b1, 32'hEEEEEEEE);
        idle(); expect_out("t1.c3", 1'b1, 32'hDDDDDDDD);
        idle(); expect_out("t1.c4", 1'b1, 32'hCCCCCCCC);
        idle(); expect_out("t1.c5", 1'b0, 32'h0);
        check("t1.hold", data_out, 32'hCCCCCCCC);

        // 2: lane 1 early by two cycles
        cycle(1'b0, 32'h0, 1'b1, 32'hEEEEEEEE); expect_out("t2.c0", 1'b0, 32'h0);
        idle(); expect_out("t2.c1", 1'b0, 32'h0);
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, 32'h0); expect_out("t2.c2", 1'b0, 32'h0);
        idle(); expect_out("t2.c3", 1'b1, 32'hFFFFFFFF);
        idle(); expect_out("t2.c4", 1'b1, 32'hEEEEEEEE);
        idle(); expect_out("t2.c5", 1'b0, 32'h0);

        // 3: gap on lane 1
        cycle(1'b1, 32'h00000003, 1'b0, 32'h0); expect_out("t3.c0", 1'b0, 32'h0);
        idle(); expect_out("t3.c1", 1'b1, 32'h00000003);
        idle(); expect_out("t3.c2", 1'b0, 32'h0);
        check("t3.hold", data_out, 32'h00000003);
        idle(); expect_out("t3.c3", 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000004); expect_out("t3.c4", 1'b0, 32'h0);
        idle(); expect_out("t3.c5", 1'b1, 32'h00000004);
        idle(); expect_out("t3.c6", 1'b0, 32'h0);

        // 4: overflow on lane 0 (A..F), F dropped
        cycle(1'b1, 32'h0000000A, 1'b0, 32'h0); expect_out("t4.a", 1'b0, 32'h0);
        cycle(1'b1, 32'h0000000B, 1'b0, 32'h0); expect_out("t4.b", 1'b1, 32'h0000000A);
        cycle(1'b1, 32'h0000000C, 1'b0, 32'h0); expect_out("t4.c", 1'b0, 32'h0);
        cycle(1'b1, 32'h0000000D, 1'b0, 32'h0); expect_out("t4.d", 1'b0, 32'h0);
        cycle(1'b1, 32'h0000000E, 1'b0, 32'h0); expect_out("t4.e", 1'b0, 32'h0);
        check_err("t4.pre", 1'b0);
        cycle(1'b1, 32'h0000000F, 1'b0, 32'h0); expect_out("t4.f", 1'b0, 32'h0);
        check_err("t4.drop", 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000011); expect_out("t4.m0", 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000012); expect_out("t4.m1", 1'b1, 32'h00000011);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000013); expect_out("t4.m2", 1'b1, 32'h0000000B);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000014); expect_out("t4.m3", 1'b1, 32'h00000012);
        idle(); expect_out("t4.m4", 1'b1, 32'h0000000C);
        idle(); expect_out("t4.m5", 1'b1, 32'h00000013);
        idle(); expect_out("t4.m6", 1'b1, 32'h0000000D);
        idle(); expect_out("t4.m7", 1'b1, 32'h00000014);
        idle(); expect_out("t4.m8", 1'b1, 32'h0000000E);
        idle(); expect_out("t4.m9", 1'b0, 32'h0);
        check_err("t4.sticky", 1'b1);

        // 5: full lane 0 FIFO with sel=0, push and pop together
        pulse_reset();
        check_err("t5.rst", 1'b0);
        cycle(1'b1, 32'h00000020, 1'b0, 32'h0); expect_out("t5.f0", 1'b0, 32'h0);
        cycle(1'b1, 32'h00000021, 1'b0, 32'h0); expect_out("t5.f1", 1'b1, 32'h00000020);
        cycle(1'b1, 32'h00000022, 1'b0, 32'h0); expect_out("t5.f2", 1'b0, 32'h0);
        cycle(1'b1, 32'h00000023, 1'b0, 32'h0); expect_out("t5.f3", 1'b0, 32'h0);
        cycle(1'b1, 32'h00000024, 1'b0, 32'h0); expect_out("t5.f4", 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000030); expect_out("t5.q0", 1'b0, 32'h0);
        idle(); expect_out("t5.q1", 1'b1, 32'h00000030);
        cycle(1'b1, 32'h00000025, 1'b0, 32'h0); expect_out("t5.pp", 1'b1, 32'h00000021);
        check_err("t5.pp", 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000031); expect_out("t5.d0", 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000032); expect_out("t5.d1", 1'b1, 32'h00000031);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000033); expect_out("t5.d2", 1'b1, 32'h00000022);
        cycle(1'b0, 32'h0, 1'b1, 32'h00000034); expect_out("t5.d3", 1'b1, 32'h00000032);
        idle(); expect_out("t5.d4", 1'b1, 32'h00000023);
        idle(); expect_out("t5.d5", 1'b1, 32'h00000033);
        idle(); expect_out("t5.d6", 1'b1, 32'h00000024);
        idle(); expect_out("t5.d7", 1'b1, 32'h00000034);
        idle(); expect_out("t5.d8", 1'b1, 32'h00000025);
        idle(); expect_out("t5.d9", 1'b0, 32'h0);

        // 6: reset in the middle of the aligned burst
        pulse_reset();
        cycle(1'b1, 32'hFFFFFFFF, 1'b1, 32'hEEEEEEEE); expect_out("t6.c0", 1'b0, 32'h0);
        cycle(1'b1, 32'hDDDDDDDD, 1'b1, 32'hCCCCCCCC); expect_out("t6.c1", 1'b1, 32'hFFFFFFFF);
        idle(); expect_out("t6.c2", 1'b1, 32'hEEEEEEEE);
        reset = 1'b1;
        #1;
        check("t6.async.data", data_out, 32'h0);
        check("t6.async.valid", {31'b0, valid_out}, 32'h0);
        reset = 1'b0;
        idle(); expect_out("t6.s0", 1'b0, 32'h0);
        idle(); expect_out("t6.s1", 1'b0, 32'h0);
        cycle(1'b1, 32'h11111111, 1'b1, 32'h22222222); expect_out("t6.n0", 1'b0, 32'h0);
        idle(); expect_out("t6.n1", 1'b1, 32'h11111111);
        idle(); expect_out("t6.n2", 1'b1, 32'h22222222);
        idle(); expect_out("t6.n3", 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
